// File: rtl/pulse_link_pkg.sv
// rtl/pulse_link_pkg.sv - shared constants, FSM states and symbol timing for the pulse link
package pulse_link_pkg;

  localparam int SHORT_GAP_DEF   = 2;
  localparam int LONG_GAP_DEF    = 6;
  localparam int WAKE_PULSES_DEF = 4;
  localparam int RX_TIMEOUT      = 1000;

  typedef enum logic [3:0] {
    IDLE,
    WAKE_HI,
    WAKE_LO,
    GAP_A,
    BIT_HI1,
    GAP_B,
    BIT_HI2,
    SEP_LO,
    DELIM_HI,
    TRAIL,
    SCAN_HI,
    SCAN_LO
  } pulse_state_e;

  function automatic int symbol_len(input int short_gap, input int long_gap);
    return short_gap + long_gap + 4;
  endfunction

endpackage

// File: rtl/pulse_tx_if.sv
// rtl/pulse_tx_if.sv - host request/status and line signals of the pulse transmitter
interface pulse_tx_if #(
  parameter int PAYLOAD_BITS = 4
);
  logic                    start;
  logic [PAYLOAD_BITS-1:0] payload;
  logic                    scan_req;
  logic                    frame_ready;
  logic                    scan_ready;
  logic                    session_active;
  logic                    done;
  logic                    scan_reject;
  logic                    DATA_OUT;

  modport master (
    output start, payload, scan_req,
    input  frame_ready, scan_ready, session_active, done, scan_reject, DATA_OUT
  );

  modport slave (
    input  start, payload, scan_req,
    output frame_ready, scan_ready, session_active, done, scan_reject, DATA_OUT
  );
endinterface

// File: rtl/pulse_gap_timer.sv
// rtl/pulse_gap_timer.sv - loadable down-counter with zero flag, optionally saturating at zero
module pulse_gap_timer #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !(SATURATE && zero)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/pulse_tx.sv
// rtl/pulse_tx.sv - pulse-position frame and scan transmitter with receiver session tracking
module pulse_tx
  import pulse_link_pkg::*;
#(
  parameter int PAYLOAD_BITS = 4,
  parameter int WAKE_PULSES  = WAKE_PULSES_DEF,
  parameter int SHORT_GAP    = SHORT_GAP_DEF,
  parameter int LONG_GAP     = LONG_GAP_DEF,
  parameter int SESSION_IDLE = 1024
) (
  input logic       CLK_IN,
  input logic       rst_n,
  pulse_tx_if.slave bus
);
  localparam int GW = $clog2(symbol_len(SHORT_GAP, LONG_GAP));
  localparam int IW = $clog2(SESSION_IDLE);
  localparam int CW = 8;

  pulse_state_e            state, state_n;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [CW-1:0]           pcnt;
  logic [GW-1:0]           gap_val;
  logic gap_zero, gap_load, idle_zero, line_hi;
  logic start_ok, scan_ok, expire, reject_n, sess_n, idle_n, wake_last, bit_last, cur_bit;

  // The line output lags the state by one cycle, so a state decodes the level of the next cycle.
  assign line_hi   = state inside {WAKE_HI, BIT_HI1, BIT_HI2, DELIM_HI, SCAN_HI};
  assign cur_bit   = shreg[PAYLOAD_BITS-1];
  assign wake_last = (pcnt == CW'(WAKE_PULSES - 1));
  assign bit_last  = (pcnt == CW'(PAYLOAD_BITS - 1));

  // Expiry is judged before the registered session flag drops, so it beats a same-edge scan.
  assign expire   = bus.session_active && idle_zero && (state == IDLE);
  assign start_ok = bus.start && bus.frame_ready;
  assign scan_ok  = bus.scan_req && bus.scan_ready && !expire;
  assign reject_n = bus.scan_req && (bus.frame_ready || (bus.scan_ready && expire));
  assign sess_n   = bus.done ? 1'b1 : (expire ? 1'b0 : bus.session_active);
  assign idle_n   = (state_n == IDLE) && (state != TRAIL);
  assign gap_load = !(state inside {GAP_A, GAP_B});

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start_ok)     state_n = WAKE_HI;
        else if (scan_ok) state_n = SCAN_HI;
      end
      WAKE_HI:  state_n = WAKE_LO;
      WAKE_LO:  state_n = wake_last ? GAP_A : WAKE_HI;
      GAP_A:    state_n = gap_zero ? BIT_HI1 : GAP_A;
      BIT_HI1:  state_n = GAP_B;
      GAP_B:    state_n = gap_zero ? BIT_HI2 : GAP_B;
      BIT_HI2:  state_n = SEP_LO;
      SEP_LO:   state_n = DELIM_HI;
      DELIM_HI: state_n = bit_last ? TRAIL : GAP_A;
      TRAIL:    state_n = IDLE;
      SCAN_HI:  state_n = SCAN_LO;
      SCAN_LO:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    gap_val = GW'(SHORT_GAP - 1);
    if (state == BIT_HI1) gap_val = cur_bit ? GW'(SHORT_GAP - 1) : GW'(LONG_GAP - 1);
    else                  gap_val = cur_bit ? GW'(LONG_GAP - 1)  : GW'(SHORT_GAP - 1);
  end

  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      shreg              <= '0;
      pcnt               <= '0;
      bus.DATA_OUT       <= 1'b0;
      bus.done           <= 1'b0;
      bus.scan_reject    <= 1'b0;
      bus.session_active <= 1'b0;
      bus.scan_ready     <= 1'b0;
      bus.frame_ready    <= 1'b1;
    end else begin
      state              <= state_n;
      bus.DATA_OUT       <= line_hi;
      bus.done           <= (state == TRAIL);
      bus.scan_reject    <= reject_n;
      bus.session_active <= sess_n;
      bus.frame_ready    <= idle_n && !sess_n;
      bus.scan_ready     <= idle_n && sess_n;
      if (start_ok)             shreg <= bus.payload;
      else if (state == SEP_LO) shreg <= shreg << 1;
      if (state == WAKE_LO)       pcnt <= wake_last ? '0 : pcnt + CW'(1);
      else if (state == DELIM_HI) pcnt <= bit_last ? '0 : pcnt + CW'(1);
    end
  end

  pulse_gap_timer #(.WIDTH(GW), .SATURATE(1'b0)) u_gap (
    .clk      (CLK_IN),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (gap_val),
    .en       (!gap_load),
    .zero     (gap_zero)
  );

  pulse_gap_timer #(.WIDTH(IW), .SATURATE(1'b1)) u_idle (
    .clk      (CLK_IN),
    .rst_n    (rst_n),
    .load     (line_hi),
    .load_val (IW'(SESSION_IDLE - 1)),
    .en       (1'b1),
    .zero     (idle_zero)
  );
endmodule

// File: tb/tb_pulse_tx.sv
// tb/tb_pulse_tx.sv - directed self-checking bench for pulse_tx
module tb_pulse_tx;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] m1011, m0000, m0110;
  int hi_1011 [16] = '{1, 3, 5, 7, 15, 18, 20, 23, 30, 32, 39, 42, 44, 51, 54, 56};
  int hi_0000 [16] = '{1, 3, 5, 7, 11, 18, 20, 23, 30, 32, 35, 42, 44, 47, 54, 56};
  int hi_0110 [11] = '{1, 3, 5, 7, 11, 18, 20, 27, 30, 32, 39};

  pulse_tx_if #(.PAYLOAD_BITS(4)) bus ();

  pulse_tx #(
    .PAYLOAD_BITS (4),
    .WAKE_PULSES  (4),
    .SHORT_GAP    (2),
    .LONG_GAP     (6),
    .SESSION_IDLE (1024)
  ) dut (
    .CLK_IN (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string name, input logic [3:0] pl, input logic [63:0] m,
                           input bit scan_too);
    bus.start    = 1'b1;
    bus.payload  = pl;
    bus.scan_req = scan_too;
    for (int k = 0; k <= 58; k++) begin
      @(negedge clk);
      chk($sformatf("%s line c%0d", name, k), bus.DATA_OUT, m[k]);
      chk($sformatf("%s done c%0d", name, k), bus.done, k == 57);
      chk($sformatf("%s reject c%0d", name, k), bus.scan_reject, (k == 0) && scan_too);
      chk($sformatf("%s frame_ready c%0d", name, k), bus.frame_ready, 1'b0);
      chk($sformatf("%s scan_ready c%0d", name, k), bus.scan_ready, k == 58);
      chk($sformatf("%s session c%0d", name, k), bus.session_active, k == 58);
      if (k == 0) begin
        bus.start    = 1'b0;
        bus.scan_req = 1'b0;
        bus.payload  = ~pl;
      end
      if (k == 10) begin
        bus.start    = 1'b1;
        bus.scan_req = 1'b1;
      end
      if (k == 13) begin
        bus.start    = 1'b0;
        bus.scan_req = 1'b0;
      end
    end
  endtask

  initial begin
    m1011 = '0;
    m0000 = '0;
    m0110 = '0;
    foreach (hi_1011[i]) m1011[hi_1011[i]] = 1'b1;
    foreach (hi_0000[i]) m0000[hi_0000[i]] = 1'b1;
    foreach (hi_0110[i]) m0110[hi_0110[i]] = 1'b1;
    bus.start    = 1'b0;
    bus.payload  = 4'b0000;
    bus.scan_req = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst line", bus.DATA_OUT, 1'b0);
    chk("rst frame_ready", bus.frame_ready, 1'b1);
    chk("rst scan_ready", bus.scan_ready, 1'b0);
    chk("rst session", bus.session_active, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst reject", bus.scan_reject, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst frame_ready", bus.frame_ready, 1'b1);

    run_frame("f1011", 4'b1011, m1011, 1'b0);

    // three back-to-back scans, with start held to show it is ignored in a live session
    bus.scan_req = 1'b1;
    bus.start    = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("scan line c%0d", k), bus.DATA_OUT, (k == 1) || (k == 4) || (k == 7));
      chk($sformatf("scan session c%0d", k), bus.session_active, 1'b1);
      chk($sformatf("scan frame_ready c%0d", k), bus.frame_ready, 1'b0);
      chk($sformatf("scan reject c%0d", k), bus.scan_reject, 1'b0);
      if (k == 6) begin
        bus.scan_req = 1'b0;
        bus.start    = 1'b0;
      end
    end

    // last high in relative cycle 7, so the session dies in cycle 7 + 1024
    for (int k = 10; k <= 1034; k++) begin
      @(negedge clk);
      if (k == 1030) begin
        chk("pre-expiry session", bus.session_active, 1'b1);
        chk("pre-expiry scan_ready", bus.scan_ready, 1'b1);
        bus.scan_req = 1'b1;
      end
      if (k == 1031) begin
        chk("expiry session", bus.session_active, 1'b0);
        chk("expiry frame_ready", bus.frame_ready, 1'b1);
        chk("expiry scan_ready", bus.scan_ready, 1'b0);
        chk("expiry collision reject", bus.scan_reject, 1'b1);
        bus.scan_req = 1'b0;
      end
      if (k == 1032 || k == 1033) begin
        chk($sformatf("expiry line c%0d", k), bus.DATA_OUT, 1'b0);
        chk($sformatf("expiry reject c%0d", k), bus.scan_reject, 1'b0);
      end
    end

    bus.scan_req = 1'b1;
    @(negedge clk);
    chk("late scan reject", bus.scan_reject, 1'b1);
    bus.scan_req = 1'b0;
    @(negedge clk);
    chk("late scan line", bus.DATA_OUT, 1'b0);
    chk("late scan reject clear", bus.scan_reject, 1'b0);

    // frame after timeout, cut by reset while the third bit's first pulse is on the line
    bus.start   = 1'b1;
    bus.payload = 4'b0110;
    for (int k = 0; k <= 39; k++) begin
      @(negedge clk);
      chk($sformatf("f0110 line c%0d", k), bus.DATA_OUT, m0110[k]);
      if (k == 0) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst line", bus.DATA_OUT, 1'b0);
    chk("midrst frame_ready", bus.frame_ready, 1'b1);
    chk("midrst done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("after-rst done %0d", k), bus.done, 1'b0);
      chk($sformatf("after-rst line %0d", k), bus.DATA_OUT, 1'b0);
      chk($sformatf("after-rst frame_ready %0d", k), bus.frame_ready, 1'b1);
    end

    run_frame("f0000", 4'b0000, m0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
